// File: rtl/bus_pkg.sv
// Shared types and address map for the sys_bus memory/MMIO subsystem.
// The UART block is only built when SYS_BUS_UART_EN is defined.
package bus_pkg;

  typedef enum logic [1:0] {
    UNIT_BYTE = 2'b00,
    UNIT_HALF = 2'b01,
    UNIT_WORD = 2'b10
  } mem_unit_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_LO = 32'h0200_4000;
  localparam logic [31:0] MTIMECMP_HI = 32'h0200_4004;
  localparam logic [31:0] MTIME_LO    = 32'h0200_BFF8;
  localparam logic [31:0] MTIME_HI    = 32'h0200_BFFC;
  localparam logic [31:0] UART_TXDATA = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS = 32'h1000_0004;

  function automatic logic is_timer_addr(input logic [31:0] a);
    return (a == MTIMECMP_LO) || (a == MTIMECMP_HI) ||
           (a == MTIME_LO)    || (a == MTIME_HI);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; tx is registered so the line never glitches.
// Only instantiated by sys_bus when SYS_BUS_UART_EN is defined.
module uart_tx
  import bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shreg;
  logic          tx_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= UART_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      tx      <= tx_next;
    end
  end

  // Frame data is only consumed while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (start && state == UART_IDLE) shreg <= data;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_idx;
    unique case (state)
      UART_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (start) state_next = UART_START;
      end
      UART_START: begin
        if (cnt == CNT_LAST) begin
          state_next = UART_DATA;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end
      UART_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = UART_STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      UART_STOP: begin
        if (cnt == CNT_LAST) begin
          state_next = UART_IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = UART_IDLE;
    endcase
  end

  // Line level follows the state being entered; shreg is loaded on that same edge.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      UART_START: tx_next = 1'b0;
      UART_DATA:  tx_next = (state == UART_IDLE) ? data[bit_next] : shreg[bit_next];
      default:    tx_next = 1'b1;
    endcase
  end

  assign busy = (state != UART_IDLE);

endmodule

// File: rtl/sys_bus.sv
// Memory/MMIO subsystem: byte-enabled RAM, timer write path and optional UART.
// Define SYS_BUS_UART_EN to build the UART at TXDATA/STATUS; otherwise those addresses fault.
module sys_bus
  import bus_pkg::*;
#(
  parameter int RAM_BYTES    = 65536,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wd,
  output logic [31:0] mem_rd,
  input  logic [1:0]  mem_rd_unit,
  input  logic [1:0]  mem_wd_unit,
  input  logic [63:0] mtime,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime_next,
  output logic [63:0] mtimecmp_next,
  output logic        mtime_we,
  output logic        access_fault,
  output logic        addr_misaligned,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_BYTES);
  localparam int WORDS = RAM_BYTES / 4;
  localparam logic [32:0] RAM_LIMIT = 33'(RAM_BYTES);

  function automatic logic [31:0] lane_data(input logic [31:0] wd, input logic [1:0] unit);
    case (unit)
      UNIT_BYTE: return {4{wd[7:0]}};
      UNIT_HALF: return {2{wd[15:0]}};
      default:   return wd;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] unit, input logic [1:0] ofs);
    case (unit)
      UNIT_BYTE: return 4'b0001 << ofs;
      UNIT_HALF: return ofs[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rd_extract(input logic [31:0] word, input logic [1:0] unit,
                                             input logic [1:0] ofs);
    logic [31:0] sh;
    sh = word >> {ofs, 3'b000};
    case (unit)
      UNIT_BYTE: return {24'h0, sh[7:0]};
      UNIT_HALF: return {16'h0, sh[15:0]};
      default:   return word;
    endcase
  endfunction

  logic [31:0]   ram [WORDS];
  logic [AW-3:0] ram_idx;
  logic [1:0]    unit;
  logic          active, bad_size, misal, in_ram, in_timer, in_uart, mmio, map_fault, ok;
  logic          wr_ok;
  logic [31:0]   rd_word;
  logic          busy, overrun;

  assign ram_idx  = mem_addr[AW-1:2];
  assign active   = mem_re | mem_we;
  assign unit     = mem_we ? mem_wd_unit : mem_rd_unit;
  assign bad_size = (unit == 2'b11);
  assign misal    = ((unit == UNIT_HALF) && mem_addr[0]) ||
                    ((unit == UNIT_WORD) && (mem_addr[1:0] != 2'b00));

  assign in_ram   = ({1'b0, mem_addr} - {1'b0, RAM_BASE}) < RAM_LIMIT;
  assign in_timer = is_timer_addr(mem_addr);
`ifdef SYS_BUS_UART_EN
  assign in_uart  = (mem_addr == UART_TXDATA) || (mem_addr == UART_STATUS);
`else
  assign in_uart  = 1'b0;
`endif
  assign mmio      = in_timer | in_uart;
  assign map_fault = !(in_ram | mmio) || (mmio && unit != UNIT_WORD);

  // Fault priority: bad size, then misalignment, then mapping.
  assign access_fault    = active && (bad_size || (!misal && map_fault));
  assign addr_misaligned = active && !bad_size && misal;
  assign ok              = active && !bad_size && !misal && !map_fault;
  assign wr_ok           = ok && mem_we;

  always_ff @(posedge clk) begin
    if (wr_ok && in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en(unit, mem_addr[1:0])[i])
          ram[ram_idx][8*i +: 8] <= lane_data(mem_wd, unit)[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_ram)                         rd_word = ram[ram_idx];
    else if (mem_addr == MTIMECMP_LO)   rd_word = mtimecmp[31:0];
    else if (mem_addr == MTIMECMP_HI)   rd_word = mtimecmp[63:32];
    else if (mem_addr == MTIME_LO)      rd_word = mtime[31:0];
    else if (mem_addr == MTIME_HI)      rd_word = mtime[63:32];
    else if (mem_addr == UART_STATUS)   rd_word = {30'h0, overrun, busy};
  end

  assign mem_rd = (ok && !mem_we) ? rd_extract(rd_word, unit, mem_addr[1:0]) : 32'h0;

  // Each half is replaced independently; no carry into the other half.
  always_comb begin
    mtime_next    = mtime;
    mtimecmp_next = mtimecmp;
    if (wr_ok) begin
      if (mem_addr == MTIME_LO)    mtime_next[31:0]     = mem_wd;
      if (mem_addr == MTIME_HI)    mtime_next[63:32]    = mem_wd;
      if (mem_addr == MTIMECMP_LO) mtimecmp_next[31:0]  = mem_wd;
      if (mem_addr == MTIMECMP_HI) mtimecmp_next[63:32] = mem_wd;
    end
  end

  assign mtime_we = wr_ok && in_timer;

`ifdef SYS_BUS_UART_EN
  logic tx_write, status_write;

  assign tx_write     = wr_ok && (mem_addr == UART_TXDATA);
  assign status_write = wr_ok && (mem_addr == UART_STATUS);

  always_ff @(posedge clk) begin
    if (reset)                  overrun <= 1'b0;
    else if (status_write)      overrun <= 1'b0;
    else if (tx_write && busy)  overrun <= 1'b1;
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (tx_write && !busy),
    .data  (mem_wd[7:0]),
    .busy  (busy),
    .tx    (uart_tx)
  );
`else
  assign busy    = 1'b0;
  assign overrun = 1'b0;
  assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_sys_bus.sv
// Directed self-checking bench for sys_bus; UART checks adapt to SYS_BUS_UART_EN.
`timescale 1ns/1ps
module tb_sys_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [1:0]  mem_rd_unit, mem_wd_unit;
  logic [63:0] mtime, mtimecmp, mtime_next, mtimecmp_next;
  logic        mtime_we, access_fault, addr_misaligned, uart_tx;

  int n_chk = 0;
  int n_err = 0;

  sys_bus #(.RAM_BYTES(65536), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_rd_unit(mem_rd_unit), .mem_wd_unit(mem_wd_unit),
    .mtime(mtime), .mtimecmp(mtimecmp), .mtime_next(mtime_next), .mtimecmp_next(mtimecmp_next),
    .mtime_we(mtime_we), .access_fault(access_fault), .addr_misaligned(addr_misaligned),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wd = '0;
    mem_rd_unit = 2'b10; mem_wd_unit = 2'b10;
  endtask

  // Present a request and let the combinational outputs settle.
  task automatic rd(input logic [31:0] a, input logic [1:0] u);
    idle(); mem_re = 1'b1; mem_addr = a; mem_rd_unit = u; #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] u, input logic [31:0] d);
    idle(); mem_we = 1'b1; mem_addr = a; mem_wd_unit = u; mem_wd = d; #1;
  endtask

  initial begin
    logic [9:0] frame;
    idle();
    mtime    = 64'h0000_0005_0000_0007;
    mtimecmp = 64'h0000_0001_0000_0000;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_tx", uart_tx, 1);
    check("idle_af", access_fault, 0);
    check("idle_mis", addr_misaligned, 0);
    check("idle_rd", mem_rd, 0);
    check("idle_mwe", mtime_we, 0);

    // RAM word write then sub-word reads
    wr(32'h100, 2'b10, 32'hDEAD_BEEF);
    check("wr_af", access_fault, 0);
    check("wr_rd0", mem_rd, 0);
    tick();
    rd(32'h101, 2'b00); check("rd_b101", mem_rd, 32'h0000_00BE);
    rd(32'h102, 2'b01); check("rd_h102", mem_rd, 32'h0000_DEAD);
    rd(32'h100, 2'b10); check("rd_w100", mem_rd, 32'hDEAD_BEEF);

    // Byte and half lanes
    wr(32'h200, 2'b10, 32'h1122_3344); tick();
    wr(32'h203, 2'b00, 32'hFFFF_FF55); tick();
    rd(32'h200, 2'b10); check("rd_w200", mem_rd, 32'h5522_3344);
    wr(32'h204, 2'b10, 32'h0); tick();
    wr(32'h206, 2'b01, 32'h1234_ABCD); tick();
    rd(32'h204, 2'b10); check("rd_w204", mem_rd, 32'hABCD_0000);
    rd(32'h206, 2'b00); check("rd_b206", mem_rd, 32'h0000_00CD);

    // Both strobes: write wins and its size is used
    idle(); mem_re = 1'b1; mem_we = 1'b1; mem_addr = 32'h208; mem_rd_unit = 2'b11;
    mem_wd_unit = 2'b10; mem_wd = 32'hCAFE_F00D; #1;
    check("both_af", access_fault, 0);
    tick();
    rd(32'h208, 2'b10); check("both_rd", mem_rd, 32'hCAFE_F00D);

    // Fault priority
    rd(32'h101, 2'b01);
    check("mis_h_flag", addr_misaligned, 1);
    check("mis_h_af", access_fault, 0);
    check("mis_h_rd", mem_rd, 0);
    rd(32'h102, 2'b10); check("mis_w_flag", addr_misaligned, 1);
    rd(32'h101, 2'b11);
    check("sz11_af", access_fault, 1);
    check("sz11_mis", addr_misaligned, 0);
    rd(32'h0001_0000, 2'b10); check("ram_end_af", access_fault, 1);
    rd(32'h0000_FFFC, 2'b10); check("ram_top_af", access_fault, 0);

    // Unmapped write leaves RAM alone (no aliasing onto 0x100)
    wr(32'h0300_0100, 2'b10, 32'h1234_5678);
    check("unm_af", access_fault, 1);
    check("unm_mwe", mtime_we, 0);
    check("unm_mis", addr_misaligned, 0);
    tick();
    rd(32'h100, 2'b10); check("unm_ram", mem_rd, 32'hDEAD_BEEF);

    // Timer write path
    wr(32'h0200_4000, 2'b10, 32'h20);
    check("tcmp_we", mtime_we, 1);
    check("tcmp_next", mtimecmp_next, 64'h0000_0001_0000_0020);
    check("tcmp_mt", mtime_next, 64'h0000_0005_0000_0007);
    wr(32'h0200_BFF8, 2'b10, 32'hFFFF_FFFF);
    check("tlo_next", mtime_next, 64'h0000_0005_FFFF_FFFF);
    check("tlo_cmp", mtimecmp_next, 64'h0000_0001_0000_0000);
    wr(32'h0200_BFFC, 2'b10, 32'h9);
    check("thi_next", mtime_next, 64'h0000_0009_0000_0007);
    wr(32'h0200_4004, 2'b10, 32'h77);
    check("tchi_next", mtimecmp_next, 64'h0000_0077_0000_0000);
    wr(32'h0200_4000, 2'b00, 32'h20);
    check("tbyte_af", access_fault, 1);
    check("tbyte_we", mtime_we, 0);
    check("tbyte_nx", mtimecmp_next, 64'h0000_0001_0000_0000);
    rd(32'h0200_4004, 2'b10); check("tcmp_rd", mem_rd, 32'h1);
    rd(32'h0200_BFF8, 2'b10); check("tmt_rd", mem_rd, 32'h7);

`ifdef SYS_BUS_UART_EN
    // 0xA5 framed LSB first: start, 1,0,1,0,0,1,0,1, stop
    frame = 10'b1_1010_0101_0;
    rd(32'h1000_0000, 2'b10); check("txd_rd0", mem_rd, 0);
    wr(32'h1000_0000, 2'b10, 32'h0000_00A5);
    check("txd_af", access_fault, 0);
    tick();
    for (int k = 0; k < 40; k++) begin
      rd(32'h1000_0004, 2'b10);
      check($sformatf("frame_tx%0d", k), uart_tx, frame[k/4]);
      check($sformatf("frame_busy%0d", k), mem_rd, 1);
      tick();
    end
    rd(32'h1000_0004, 2'b10);
    check("done_busy", mem_rd, 0);
    check("done_tx", uart_tx, 1);

    // Overrun, clear, then reset mid-frame
    wr(32'h1000_0000, 2'b10, 32'h0F); tick();
    wr(32'h1000_0000, 2'b10, 32'h33); tick();
    rd(32'h1000_0004, 2'b10); check("ovr_stat", mem_rd, 3);
    wr(32'h1000_0004, 2'b10, 32'h0); tick();
    rd(32'h1000_0004, 2'b10); check("ovr_clr", mem_rd, 1);
    wr(32'h1000_0000, 2'b00, 32'h1); check("txd_byte_af", access_fault, 1);
    idle(); tick();
    check("mid_tx", uart_tx, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    rd(32'h1000_0004, 2'b10);
    check("rst_mid_tx", uart_tx, 1);
    check("rst_mid_stat", mem_rd, 0);
`else
    frame = '0;
    wr(32'h1000_0000, 2'b10, 32'hA5); check("noua_txd_af", access_fault, 1);
    tick();
    rd(32'h1000_0004, 2'b10);
    check("noua_st_af", access_fault, 1);
    check("noua_st_rd", mem_rd, 0);
    tick(); tick();
    check("noua_tx", uart_tx, 1);
`endif

    idle(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
